// File: rtl/data_mem_resp.sv
// data_mem_resp: single-outstanding load/store responder with byte/half/word access and load extension
module data_mem_resp #(
    parameter int ADDR_WIDTH = 6
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic        dataWe,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        ready,
    output logic        rvalid,
    output logic [31:0] rdata,
    output logic        err
);
    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
    state_t state, state_nx;
    logic we_q, err_q;
    logic [2:0] f3_q;
    logic [31:0] addr_q, wdata_q, rdata_q;
    logic [31:0] mem [2**ADDR_WIDTH];
    logic [ADDR_WIDTH-1:0] idx;
    logic illegal, misaligned, out_of_range, bad;
    logic [31:0] word, load_data, store_data;
    logic [15:0] half;
    logic [7:0] lane_byte;
    logic [3:0] be;

    // access decode, error detection and lane steering from the latched request
    always_comb begin
        idx          = addr_q[ADDR_WIDTH+1:2];
        out_of_range = |addr_q[31:ADDR_WIDTH+2];
        illegal      = (f3_q[1:0] == 2'b11) | (we_q ? f3_q[2] : f3_q == 3'b110);
        misaligned   = (f3_q[1:0] == 2'b01 & addr_q[0]) | (f3_q[1:0] == 2'b10 & |addr_q[1:0]);
        bad          = illegal | misaligned | out_of_range;
        word         = mem[idx];
        lane_byte    = word[{addr_q[1:0], 3'b000} +: 8];
        half         = addr_q[1] ? word[31:16] : word[15:0];
        load_data    = f3_q[1:0] == 2'b00 ? {{24{lane_byte[7] & ~f3_q[2]}}, lane_byte} :
                       f3_q[1:0] == 2'b01 ? {{16{half[15] & ~f3_q[2]}}, half} : word;
        be           = f3_q[1:0] == 2'b00 ? 4'b0001 << addr_q[1:0] :
                       f3_q[1:0] == 2'b01 ? (addr_q[1] ? 4'b1100 : 4'b0011) : 4'b1111;
        store_data   = f3_q[1:0] == 2'b00 ? {4{wdata_q[7:0]}} :
                       f3_q[1:0] == 2'b01 ? {2{wdata_q[15:0]}} : wdata_q;
    end

    // next-state and handshake outputs; completion data is only visible while rvalid
    always_comb begin
        state_nx = IDLE;
        ready    = 1'b0;
        rvalid   = 1'b0;
        case (state)
            IDLE: begin
                ready    = 1'b1;
                state_nx = req ? ACCESS : IDLE;
            end
            ACCESS: state_nx = RESP;
            RESP: rvalid = 1'b1;
            default: state_nx = IDLE;
        endcase
        rdata = rvalid ? rdata_q : '0;
        err   = rvalid & err_q;
    end

    // state, request latch and response registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            we_q    <= 1'b0;
            f3_q    <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state <= state_nx;
            if (state == IDLE && req) begin
                we_q    <= dataWe;
                f3_q    <= funct3;
                addr_q  <= addr;
                wdata_q <= wdata;
            end
            if (state == ACCESS) begin
                rdata_q <= (bad | we_q) ? '0 : load_data;
                err_q   <= bad;
            end
        end
    end

    // byte-lane store commit on the ACCESS->RESP edge; an async reset in ACCESS suppresses it
    always_ff @(posedge clk) begin
        if (state == ACCESS && we_q && !bad)
            for (int i = 0; i < 4; i++)
                if (be[i]) mem[idx][8*i +: 8] <= store_data[8*i +: 8];
    end
endmodule

// File: tb/tb_data_mem_resp.sv
// tb_data_mem_resp: scoreboard bench for the data-memory responder
module tb_data_mem_resp;
    localparam logic [2:0] F_B = 3'b000, F_H = 3'b001, F_W = 3'b010, F_BU = 3'b100, F_HU = 3'b101;

    typedef struct {
        logic        we;
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] wd;
        logic [31:0] rd;
        logic        e;
    } row_t;

    logic clk = 1'b0;
    logic reset, req, dataWe;
    logic [2:0] funct3;
    logic [31:0] addr, wdata, rdata;
    logic ready, rvalid, err;
    int n_cmp = 0;
    int n_bad = 0;
    logic [32:0] sb[$];

    always #5 clk = ~clk;

    data_mem_resp #(.ADDR_WIDTH(6)) dut (
        .clk(clk), .reset(reset), .req(req), .dataWe(dataWe), .funct3(funct3),
        .addr(addr), .wdata(wdata), .ready(ready), .rvalid(rvalid), .rdata(rdata), .err(err)
    );

    // drive one request, push its expectation, wait (bounded) for the completion pulse
    task automatic txn(input logic we, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd,
                       input logic [31:0] e_rd, input logic e_err,
                       output logic [32:0] obs, output logic [32:0] ex, output int lat, output logic rdy_low);
        int w = 0;
        @(negedge clk);
        while (!ready && w < 10) begin
            @(negedge clk);
            w++;
        end
        req = 1'b1; dataWe = we; funct3 = f3; addr = a; wdata = wd;
        sb.push_back({e_err, e_rd});
        @(posedge clk);
        #1;
        req = 1'b0; dataWe = 1'($urandom); funct3 = 3'($urandom); addr = $urandom; wdata = $urandom;
        obs = 'x; lat = -1; rdy_low = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            if (ready) rdy_low = 1'b0;
            if (rvalid) begin
                obs = {err, rdata};
                lat = i;
                break;
            end
        end
        ex = sb.pop_front();
    endtask

    task automatic test_reset();
        n_cmp++;
        if ({ready, rvalid, err, rdata} !== {1'b1, 1'b0, 1'b0, 32'h0}) begin
            n_bad++;
            $display("FAIL reset: got ready=%b rvalid=%b err=%b rdata=%h, want 1 0 0 00000000", ready, rvalid, err, rdata);
        end
    endtask

    task automatic test_word();
        row_t rows[2];
        logic [32:0] obs, ex; int lat; logic rl;
        rows = '{'{1'b1, F_W, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0},
                 '{1'b0, F_W, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0}};
        foreach (rows[i]) begin
            txn(rows[i].we, rows[i].f3, rows[i].a, rows[i].wd, rows[i].rd, rows[i].e, obs, ex, lat, rl);
            n_cmp++;
            if (obs !== ex) begin n_bad++; $display("FAIL word[%0d]: got err=%b rdata=%h, want err=%b rdata=%h", i, obs[32], obs[31:0], ex[32], ex[31:0]); end
            n_cmp++;
            if (lat != 2) begin n_bad++; $display("FAIL word_latency[%0d]: got %0d, want 2", i, lat); end
            n_cmp++;
            if (rl !== 1'b1) begin n_bad++; $display("FAIL word_ready_low[%0d]: ready seen high while busy, want low", i); end
        end
    endtask

    task automatic test_bytes();
        row_t rows[4];
        logic [32:0] obs, ex; int lat; logic rl;
        rows = '{'{1'b1, F_W, 32'h20, 32'h00000000, 32'h0, 1'b0},
                 '{1'b1, F_B, 32'h23, 32'h000000AB, 32'h0, 1'b0},
                 '{1'b1, F_H, 32'h20, 32'h00001234, 32'h0, 1'b0},
                 '{1'b0, F_W, 32'h20, 32'h0, 32'hAB001234, 1'b0}};
        foreach (rows[i]) begin
            txn(rows[i].we, rows[i].f3, rows[i].a, rows[i].wd, rows[i].rd, rows[i].e, obs, ex, lat, rl);
            n_cmp++;
            if (obs !== ex || lat != 2) begin n_bad++; $display("FAIL bytes[%0d]: got err=%b rdata=%h lat=%0d, want err=%b rdata=%h lat=2", i, obs[32], obs[31:0], lat, ex[32], ex[31:0]); end
        end
    endtask

    task automatic test_ext();
        row_t rows[11];
        logic [32:0] obs, ex; int lat; logic rl;
        rows = '{'{1'b1, F_W,  32'h30, 32'h00008080, 32'h0, 1'b0},
                 '{1'b0, F_B,  32'h30, 32'h0, 32'hFFFFFF80, 1'b0},
                 '{1'b0, F_BU, 32'h30, 32'h0, 32'h00000080, 1'b0},
                 '{1'b0, F_H,  32'h30, 32'h0, 32'hFFFF8080, 1'b0},
                 '{1'b0, F_HU, 32'h30, 32'h0, 32'h00008080, 1'b0},
                 '{1'b0, F_B,  32'h31, 32'h0, 32'hFFFFFF80, 1'b0},
                 '{1'b1, F_W,  32'h34, 32'h12345678, 32'h0, 1'b0},
                 '{1'b0, F_B,  32'h37, 32'h0, 32'h00000012, 1'b0},
                 '{1'b0, F_H,  32'h36, 32'h0, 32'h00001234, 1'b0},
                 '{1'b0, F_BU, 32'h35, 32'h0, 32'h00000056, 1'b0},
                 '{1'b0, F_HU, 32'h34, 32'h0, 32'h00005678, 1'b0}};
        foreach (rows[i]) begin
            txn(rows[i].we, rows[i].f3, rows[i].a, rows[i].wd, rows[i].rd, rows[i].e, obs, ex, lat, rl);
            n_cmp++;
            if (obs !== ex || lat != 2) begin n_bad++; $display("FAIL ext[%0d]: got err=%b rdata=%h lat=%0d, want err=%b rdata=%h lat=2", i, obs[32], obs[31:0], lat, ex[32], ex[31:0]); end
        end
    endtask

    task automatic test_errors();
        row_t rows[12];
        logic [32:0] obs, ex; int lat; logic rl;
        rows = '{'{1'b1, F_W,    32'h12, 32'hCAFEF00D, 32'h0, 1'b1},
                 '{1'b0, F_W,    32'h10, 32'h0, 32'hDEADBEEF, 1'b0},
                 '{1'b0, F_H,    32'h31, 32'h0, 32'h0, 1'b1},
                 '{1'b0, F_W,    32'h100, 32'h0, 32'h0, 1'b1},
                 '{1'b0, 3'b011, 32'h10, 32'h0, 32'h0, 1'b1},
                 '{1'b0, F_W,    32'h32, 32'h0, 32'h0, 1'b1},
                 '{1'b1, F_H,    32'h33, 32'hFFFFFFFF, 32'h0, 1'b1},
                 '{1'b1, 3'b100, 32'h10, 32'h0, 32'h0, 1'b1},
                 '{1'b1, 3'b011, 32'h10, 32'h0, 32'h0, 1'b1},
                 '{1'b0, 3'b110, 32'h10, 32'h0, 32'h0, 1'b1},
                 '{1'b0, F_W,    32'h80000010, 32'h0, 32'h0, 1'b1},
                 '{1'b0, F_W,    32'h10, 32'h0, 32'hDEADBEEF, 1'b0}};
        foreach (rows[i]) begin
            txn(rows[i].we, rows[i].f3, rows[i].a, rows[i].wd, rows[i].rd, rows[i].e, obs, ex, lat, rl);
            n_cmp++;
            if (obs !== ex || lat != 2) begin n_bad++; $display("FAIL errors[%0d]: got err=%b rdata=%h lat=%0d, want err=%b rdata=%h lat=2", i, obs[32], obs[31:0], lat, ex[32], ex[31:0]); end
        end
    endtask

    task automatic test_handshake();
        int n_rv = 0;
        logic [32:0] ex;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            if (rvalid) begin
                n_rv++;
                ex = sb.size() > 0 ? sb.pop_front() : 'x;
                n_cmp++;
                if ({err, rdata} !== ex) begin n_bad++; $display("FAIL handshake_data[%0d]: got err=%b rdata=%h, want err=%b rdata=%h", i, err, rdata, ex[32], ex[31:0]); end
            end
            if (i < 12) begin
                n_cmp++;
                if (ready !== (i % 3 == 0)) begin n_bad++; $display("FAIL handshake_ready[%0d]: got %b, want %b", i, ready, i % 3 == 0); end
                req = 1'b1; dataWe = 1'b0; funct3 = F_W; wdata = $urandom;
                addr = (i % 2 == 1) ? 32'h10 : 32'h20;
                if (i % 3 == 0) sb.push_back({1'b0, (i % 2 == 1) ? 32'hDEADBEEF : 32'hAB001234});
            end else req = 1'b0;
        end
        n_cmp++;
        if (n_rv != 4 || sb.size() != 0) begin n_bad++; $display("FAIL handshake_count: got %0d pulses (%0d pending), want 4 (0)", n_rv, sb.size()); end
    endtask

    task automatic test_reset_mid();
        logic [32:0] obs, ex; int lat; logic rl;
        int n_rv = 0;
        txn(1'b1, F_W, 32'h40, 32'h11111111, 32'h0, 1'b0, obs, ex, lat, rl);
        n_cmp++;
        if (obs !== ex) begin n_bad++; $display("FAIL reset_mid_pre: got err=%b rdata=%h, want err=%b rdata=%h", obs[32], obs[31:0], ex[32], ex[31:0]); end
        @(negedge clk);
        req = 1'b1; dataWe = 1'b1; funct3 = F_W; addr = 32'h40; wdata = 32'h55AA55AA;
        @(posedge clk);
        #1 req = 1'b0;
        #2 reset = 1'b0;
        #1;
        n_cmp++;
        if ({ready, rvalid, err, rdata} !== {1'b1, 1'b0, 1'b0, 32'h0}) begin
            n_bad++;
            $display("FAIL reset_mid_async: got ready=%b rvalid=%b err=%b rdata=%h, want 1 0 0 00000000", ready, rvalid, err, rdata);
        end
        @(posedge clk);
        @(negedge clk) reset = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (rvalid) n_rv++;
        end
        n_cmp++;
        if (n_rv != 0) begin n_bad++; $display("FAIL reset_mid_rvalid: got %0d pulses, want 0", n_rv); end
        txn(1'b0, F_W, 32'h40, 32'h0, 32'h11111111, 1'b0, obs, ex, lat, rl);
        n_cmp++;
        if (obs !== ex || lat != 2) begin n_bad++; $display("FAIL reset_mid_readback: got err=%b rdata=%h lat=%0d, want err=%b rdata=%h lat=2", obs[32], obs[31:0], lat, ex[32], ex[31:0]); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b0; req = 1'b0; dataWe = 1'b0; funct3 = '0; addr = '0; wdata = '0;
        #12;
        test_reset();
        @(negedge clk) reset = 1'b1;
        test_word();
        test_bytes();
        test_ext();
        test_errors();
        @(negedge clk);
        test_handshake();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
